pw_histo_mon: RTL and testbench

Synthesizable multi-channel pulse-width histogram monitor sitting beside the core on `i_clk`. It measures the width, in clock cycles, of pulses on up to NCH probe signals, for example SRAM access strobes or MCU read strobes. Per-channel, per-bin saturating counts are accumulated and can be read back through a simple registered read port. This makes the pulse-width analysis available on silicon and FPGA, in both high-pulse and low-pulse modes, with a start/stop window and clear.

---
 rtl/pw_histo_pkg.sv | 10 +
 rtl/pw_histo_ch.sv | 60 ++++++
 rtl/pw_histo_mon.sv | 54 +++++
 tb/tb_pw_histo_mon.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pw_histo_pkg.sv
// pw_histo_pkg: shared types and helpers for the pulse-width histogram monitor (polarity enum, index width, saturating increment)
package pw_histo_pkg;
  typedef enum logic {PW_HIGH = 1'b0, PW_LOW = 1'b1} pw_mode_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/pw_histo_ch.sv
// pw_histo_ch: one probe channel (i_clk/i_rst, probe/mode/en/clr in; combinational bin select sel_bin->sel_dat, sticky ovf out)
module pw_histo_ch
  import pw_histo_pkg::*;
#(
  parameter int NBIN = 20,
  parameter int CW   = 16,
  parameter int LW   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     probe,
  input  pw_mode_e                 mode,
  input  logic                     en,
  input  logic                     clr,
  input  logic [idx_w(NBIN+1)-1:0] sel_bin,
  output logic [CW-1:0]            sel_dat,
  output logic                     ovf
);
  localparam int BW = idx_w(NBIN + 1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [LW-1:0] WMAX = '1;
  logic          a, commit;
  logic [BW-1:0] b;
  logic          d_a_q, d_a_d, armed_q, armed_d, ovf_q, ovf_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] bins_q [NBIN+1];
  logic [CW-1:0] bins_d [NBIN+1];
  always_comb begin
    a       = probe ^ mode;
    b       = (int'(wcnt_q) >= NBIN) ? BW'(NBIN) : BW'(wcnt_q);
    commit  = ~a & d_a_q & armed_q & en;
    d_a_d   = a;
    wcnt_d  = clr ? '0 : (a & ~d_a_q & en) ? LW'(1) : (a & d_a_q & armed_q) ? LW'(sat_inc(32'(wcnt_q), 32'(WMAX))) : wcnt_q;
    armed_d = ~clr & en & a & (~d_a_q | armed_q);
    ovf_d   = ~clr & (ovf_q | (commit & ((bins_q[b] == CMAX) | (bins_q[0] == CMAX))));
    bins_d  = bins_q;
    if (commit) begin
      bins_d[b] = CW'(sat_inc(32'(bins_q[b]), 32'(CMAX)));
      bins_d[0] = CW'(sat_inc(32'(bins_q[0]), 32'(CMAX)));
    end
    if (clr) bins_d = '{default: '0};
    sel_dat = (int'(sel_bin) <= NBIN) ? bins_q[sel_bin] : '0;
  end
  assign ovf = ovf_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      d_a_q   <= 1'b0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
      wcnt_q  <= '0;
      bins_q  <= '{default: '0};
    end else begin
      d_a_q   <= d_a_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
      wcnt_q  <= wcnt_d;
      bins_q  <= bins_d;
    end
  end
endmodule

// File: rtl/pw_histo_mon.sv
// pw_histo_mon: NCH-channel pulse-width histogram (i_probe/i_mode/i_en/i_clr in; i_rd/i_rd_ch/i_rd_bin -> o_rd_dat/o_rd_vld one cycle later; o_ovf sticky per channel)
module pw_histo_mon
  import pw_histo_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int NBIN = 20,
  parameter int CW   = 16,
  parameter int LW   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NCH-1:0]           i_probe,
  input  logic [NCH-1:0]           i_mode,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic                     i_rd,
  input  logic [idx_w(NCH)-1:0]    i_rd_ch,
  input  logic [idx_w(NBIN+1)-1:0] i_rd_bin,
  output logic [CW-1:0]            o_rd_dat,
  output logic                     o_rd_vld,
  output logic [NCH-1:0]           o_ovf
);
  logic [CW-1:0] ch_dat [NCH];
  logic [CW-1:0] rd_dat_q, rd_dat_d;
  logic          rd_vld_q, rd_vld_d;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pw_histo_ch #(.NBIN(NBIN), .CW(CW), .LW(LW)) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .probe   (i_probe[g]),
      .mode    (pw_mode_e'(i_mode[g])),
      .en      (i_en),
      .clr     (i_clr),
      .sel_bin (i_rd_bin),
      .sel_dat (ch_dat[g]),
      .ovf     (o_ovf[g])
    );
  end
  always_comb begin
    rd_vld_d = i_rd;
    rd_dat_d = !i_rd ? rd_dat_q : (int'(i_rd_ch) < NCH) ? ch_dat[i_rd_ch] : '0;
  end
  assign o_rd_dat = rd_dat_q;
  assign o_rd_vld = rd_vld_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
    end
  end
endmodule

// File: tb/tb_pw_histo_mon.sv
// tb_pw_histo_mon: table-driven and scoreboarded self-check of pw_histo_mon
module tb_pw_histo_mon;
  import pw_histo_pkg::*;
  localparam int NCH = 2, NBIN = 20, CW = 4, LW = 8;
  logic clk = 1'b0;
  logic i_rst, i_en, i_clr, i_rd;
  logic [NCH-1:0] i_probe, i_mode, o_ovf;
  logic [idx_w(NCH)-1:0] i_rd_ch;
  logic [idx_w(NBIN+1)-1:0] i_rd_bin;
  logic [CW-1:0] o_rd_dat;
  logic o_rd_vld;
  typedef struct {int ch; int bin; int dat;} vec_t;
  typedef struct {int ch; int bin; int dat; int cyc;} exp_t;
  exp_t sb[$];
  vec_t tab[24];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  pw_histo_mon #(.NCH(NCH), .NBIN(NBIN), .CW(CW), .LW(LW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_probe(i_probe), .i_mode(i_mode), .i_en(i_en),
    .i_clr(i_clr), .i_rd(i_rd), .i_rd_ch(i_rd_ch), .i_rd_bin(i_rd_bin),
    .o_rd_dat(o_rd_dat), .o_rd_vld(o_rd_vld), .o_ovf(o_ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (o_rd_vld === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected rd_vld at cycle %0d: got 1, expected 0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd ch%0d bin%0d data", e.ch, e.bin), int'(o_rd_dat), e.dat);
        chk($sformatf("rd ch%0d bin%0d latency", e.ch, e.bin), cyc, e.cyc);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic rd(input int ch, input int bin, input int dat);
    i_rd = 1'b1;
    i_rd_ch = ch[idx_w(NCH)-1:0];
    i_rd_bin = bin[idx_w(NBIN+1)-1:0];
    sb.push_back('{ch, bin, dat, cyc + 1});
    tick(1);
    i_rd = 1'b0;
  endtask
  task automatic pulse(input int ch, input int w);
    i_probe[ch] = ~i_mode[ch];
    tick(w);
    i_probe[ch] = i_mode[ch];
    tick(2);
  endtask
  task automatic clear();
    i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i <= NBIN; i++) tab[i] = '{0, i, 0};
    tab[0].dat = 5;
    tab[1].dat = 1;
    tab[2].dat = 2;
    tab[5].dat = 1;
    tab[20].dat = 1;
    tab[21] = '{0, 25, 0};
    tab[22] = '{1, 0, 0};
    tab[23] = '{1, 3, 0};
    i_rst = 1'b1; i_en = 1'b1; i_clr = 1'b0; i_rd = 1'b0;
    i_rd_ch = '0; i_rd_bin = '0;
    i_mode = 2'b10; i_probe = 2'b10;
    tick(2);
    chk("reset rd_vld", int'(o_rd_vld), 0);
    chk("reset rd_dat", int'(o_rd_dat), 0);
    chk("reset ovf", int'(o_ovf), 0);
    i_rst = 1'b0;
    tick(1);
    pulse(0, 1); pulse(0, 2); pulse(0, 2); pulse(0, 5); pulse(0, 25);
    for (int i = 0; i < 24; i++) rd(tab[i].ch, tab[i].bin, tab[i].dat);
    clear();
    i_probe = 2'b01;
    tick(3);
    i_probe = 2'b10;
    tick(2);
    rd(0, 3, 1); rd(1, 3, 1); rd(0, 0, 1); rd(1, 0, 1); rd(1, 2, 0); rd(0, 4, 0);
    clear();
    i_en = 1'b0; i_probe[0] = 1'b1;
    tick(2);
    i_en = 1'b1;
    tick(3);
    i_probe[0] = 1'b0;
    tick(2);
    i_probe[0] = 1'b1;
    tick(2);
    i_en = 1'b0;
    tick(1);
    i_en = 1'b1;
    tick(1);
    i_probe[0] = 1'b0;
    tick(2);
    pulse(0, 4);
    rd(0, 0, 1); rd(0, 4, 1); rd(0, 3, 0); rd(0, 5, 0); rd(0, 2, 0);
    clear();
    i_probe[0] = 1'b1;
    tick(6);
    i_probe[0] = 1'b0;
    i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
    tick(1);
    rd(0, 6, 0); rd(0, 0, 0);
    pulse(0, 6);
    rd(0, 6, 1); rd(0, 0, 1);
    clear();
    for (int i = 0; i < 16; i++) begin
      i_probe[0] = 1'b1;
      tick(1);
      i_probe[0] = 1'b0;
      tick(1);
    end
    tick(1);
    rd(0, 1, 15); rd(0, 0, 15); rd(0, 2, 0);
    chk("sat ovf", int'(o_ovf), 1);
    clear();
    chk("ovf after clr", int'(o_ovf), 0);
    rd(0, 1, 0);
    pulse(0, 1);
    rd(0, 1, 1);
    tick(1);
    i_probe[0] = 1'b1;
    tick(2);
    i_rd = 1'b1; i_rd_ch = '0; i_rd_bin = 5'd1; i_rst = 1'b1;
    tick(1);
    i_rd = 1'b0;
    chk("rst mid-pulse rd_vld", int'(o_rd_vld), 0);
    chk("rst mid-pulse rd_dat", int'(o_rd_dat), 0);
    i_probe[0] = 1'b0;
    tick(1);
    i_rst = 1'b0;
    tick(1);
    rd(0, 1, 0); rd(0, 0, 0);
    pulse(0, 1);
    rd(0, 1, 1); rd(0, 0, 1);
    tick(3);
    chk("pending reads", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
